// File: rtl/systolic_edge_feeder_if.sv
// Handshake and edge bus between the operand source and one systolic edge feeder.
// The master side drives jobs and vectors; the slave side is the feeder.
interface systolic_edge_feeder_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned KW = 16
);
    logic              start;
    logic [KW-1:0]     k_len;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic [N*DW-1:0]   edge_out;
    logic [N-1:0]      edge_lane_valid;
    logic              acc_clr;
    logic              busy;
    logic              done;
    logic [KW-1:0]     stall_cnt;

    modport master (
        output start, k_len, in_valid, in_data,
        input  in_ready, edge_out, edge_lane_valid, acc_clr, busy, done, stall_cnt
    );

    modport slave (
        input  start, k_len, in_valid, in_data,
        output in_ready, edge_out, edge_lane_valid, acc_clr, busy, done, stall_cnt
    );
endinterface

// File: rtl/systolic_edge_feeder.sv
// Diagonal-skew edge feeder for a systolic array: clear, stream K vectors, zero-flush, done.
// Optional stall counter built only when FEEDER_PERF_EN is defined.
module systolic_edge_feeder #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned KW   = 16,
    parameter int unsigned TAIL = N - 1
) (
    input  logic clk,
    input  logic rst_n,
    systolic_edge_feeder_if.slave bus
);

    localparam int unsigned FLUSH_RAW = N - 1 + TAIL;
    localparam int unsigned FLUSH_LEN = (FLUSH_RAW == 0) ? 1 : FLUSH_RAW;
    localparam int unsigned FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_next;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] vec_cnt_q;
    logic [FW-1:0] flush_cnt_q;
    logic          acc_clr_q, done_q, busy_q;
    logic          acc_clr_next, done_next;
    logic          job_start;
    logic          accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_next   = state_q;
        acc_clr_next = 1'b0;
        done_next    = 1'b0;
        job_start    = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    job_start = 1'b1;
                    if (bus.k_len != '0) begin
                        state_next   = LOAD;
                        acc_clr_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (vec_cnt_q == k_len_q - KW'(1)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Job bookkeeping and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_q     <= '0;
            vec_cnt_q   <= '0;
            flush_cnt_q <= '0;
            acc_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_clr_q <= acc_clr_next;
            done_q    <= done_next;
            busy_q    <= (state_next != IDLE);
            if (job_start) begin
                k_len_q   <= bus.k_len;
                vec_cnt_q <= '0;
            end else if (accept) begin
                vec_cnt_q <= vec_cnt_q + KW'(1);
            end
            if (state_q != FLUSH) begin
                flush_cnt_q <= '0;
            end else begin
                flush_cnt_q <= flush_cnt_q + FW'(1);
            end
        end
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.acc_clr  = acc_clr_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

    // Per-lane skew lines: lane i has i+1 stages, the last one drives the edge.
    // Idle cycles shift zeros, so the lines drain to zero and stay there between jobs.
    logic [DW-1:0] lane_data [N];
    logic [N-1:0]  lane_valid;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] d_q [i+1];
        logic [i:0]    v_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) begin
                    d_q[j] <= '0;
                end
                v_q <= '0;
            end else begin
                d_q[0] <= accept ? bus.in_data[i*DW +: DW] : '0;
                v_q[0] <= accept;
                for (int j = 1; j <= i; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign lane_data[i]  = d_q[i];
        assign lane_valid[i] = v_q[i];
    end

    logic [N*DW-1:0] edge_flat;

    always_comb begin
        edge_flat = '0;
        for (int i = 0; i < N; i++) begin
            edge_flat[i*DW +: DW] = lane_data[i];
        end
    end

    assign bus.edge_out        = edge_flat;
    assign bus.edge_lane_valid = lane_valid;

`ifdef FEEDER_PERF_EN
    logic [KW-1:0] stall_q;

    // Saturating count of LOAD cycles starved of input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (job_start) begin
            stall_q <= '0;
        end else if (state_q == LOAD && !bus.in_valid && stall_q != '1) begin
            stall_q <= stall_q + KW'(1);
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Bench for systolic_edge_feeder: job-level reference model compared every cycle,
// plus directed scenarios with hand-computed lane/timing expectations.
module tb_systolic_edge_feeder;

    localparam int unsigned N         = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned KW        = 16;
    localparam int unsigned TAIL      = N - 1;
    localparam int          FLUSH_LEN = int'(N - 1 + TAIL);
    localparam int unsigned SMAX      = (1 << KW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    systolic_edge_feeder_if #(.N(N), .DW(DW), .KW(KW)) bif();

    systolic_edge_feeder #(.N(N), .DW(DW), .KW(KW), .TAIL(TAIL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bif.done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk(name, 64'(bif.done), 64'd1);
    endtask

    // Reference model: job phase plus a history of what entered the array edge.
    // Lane i shows whatever was injected i edges before the most recent one.
    logic [N*DW-1:0] h_d [N];
    logic            h_v [N];
    int              phase;
    int              rem;
    int              fl_left;
    logic            m_acc, m_done;
    int unsigned     m_stall;

    always @(posedge clk or negedge rst_n) begin : model
        logic [N*DW-1:0] nd;
        logic            nv;
        if (!rst_n) begin
            phase   = 0;
            rem     = 0;
            fl_left = 0;
            m_acc   = 1'b0;
            m_done  = 1'b0;
            m_stall = 0;
            for (int i = 0; i < N; i++) begin
                h_d[i] = '0;
                h_v[i] = 1'b0;
            end
        end else begin
            nd     = '0;
            nv     = 1'b0;
            m_acc  = 1'b0;
            m_done = 1'b0;
            case (phase)
                0: if (bif.start) begin
                    m_stall = 0;
                    if (bif.k_len == '0) begin
                        m_done = 1'b1;
                    end else begin
                        rem   = int'(bif.k_len);
                        phase = 1;
                        m_acc = 1'b1;
                    end
                end
                1: begin
                    if (bif.in_valid) begin
                        nv = 1'b1;
                        nd = bif.in_data;
                        rem--;
                        if (rem == 0) begin
                            phase   = 2;
                            fl_left = FLUSH_LEN;
                        end
                    end else if (m_stall < SMAX) begin
                        m_stall++;
                    end
                end
                default: begin
                    fl_left--;
                    if (fl_left == 0) begin
                        phase  = 0;
                        m_done = 1'b1;
                    end
                end
            endcase
            for (int i = N - 1; i > 0; i--) begin
                h_d[i] = h_d[i-1];
                h_v[i] = h_v[i-1];
            end
            h_d[0] = nd;
            h_v[0] = nv;
        end
    end

    always @(negedge clk) begin : compare
        logic [N*DW-1:0] ed;
        logic [N-1:0]    ev;
        logic [KW-1:0]   es;
        for (int i = 0; i < N; i++) begin
            ed[i*DW +: DW] = h_d[i][i*DW +: DW];
            ev[i]          = h_v[i];
        end
`ifdef FEEDER_PERF_EN
        es = KW'(m_stall);
`else
        es = '0;
`endif
        chk("edge_out",        64'(bif.edge_out),        64'(ed));
        chk("edge_lane_valid", 64'(bif.edge_lane_valid), 64'(ev));
        chk("acc_clr",         64'(bif.acc_clr),         64'(m_acc));
        chk("done",            64'(bif.done),            64'(m_done));
        chk("busy",            64'(bif.busy),            64'(phase != 0));
        chk("in_ready",        64'(bif.in_ready),        64'(phase == 1));
        chk("stall_cnt",       64'(bif.stall_cnt),       64'(es));
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_edge"},  64'(bif.edge_out),        64'd0);
        chk({tag, "_valid"}, 64'(bif.edge_lane_valid), 64'd0);
        chk({tag, "_acc"},   64'(bif.acc_clr),         64'd0);
        chk({tag, "_done"},  64'(bif.done),            64'd0);
        chk({tag, "_busy"},  64'(bif.busy),            64'd0);
        chk({tag, "_ready"}, 64'(bif.in_ready),        64'd0);
        chk({tag, "_stall"}, 64'(bif.stall_cnt),       64'd0);
    endtask

    initial begin
        logic [N*DW-1:0] vec [3];
        logic [DW-1:0]   l0 [11];
        logic [DW-1:0]   l3 [11];
        logic            dn [11];
        logic            ac [11];
        int              accepts;
        int              dones;

        bif.start    = 1'b0;
        bif.k_len    = '0;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;

        // Power-on reset, checked asynchronously before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back job, k_len=3
        vec[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        vec[1] = {8'd8, 8'd7, 8'd6, 8'd5};
        vec[2] = {8'd12, 8'd11, 8'd10, 8'd9};
        bif.start = 1'b1;
        bif.k_len = KW'(3);
        step();
        bif.start = 1'b0;
        chk("t1_acc_clr_pulse", 64'(bif.acc_clr),  64'd1);
        chk("t1_ready",         64'(bif.in_ready), 64'd1);
        bif.in_valid = 1'b1;
        bif.in_data  = vec[0];
        step();
        for (int k = 1; k <= 10; k++) begin
            l0[k] = bif.edge_out[0 +: DW];
            l3[k] = bif.edge_out[3*DW +: DW];
            dn[k] = bif.done;
            ac[k] = bif.acc_clr;
            if (k < 3) begin
                bif.in_data = vec[k];
            end else begin
                bif.in_valid = 1'b0;
                bif.in_data  = '0;
            end
            step();
        end
        chk("t1_acc_clr_once", 64'(ac[1]), 64'd0);
        chk("t1_l0_c1", 64'(l0[1]), 64'd1);
        chk("t1_l0_c2", 64'(l0[2]), 64'd5);
        chk("t1_l0_c3", 64'(l0[3]), 64'd9);
        chk("t1_l0_c4", 64'(l0[4]), 64'd0);
        chk("t1_l3_c3", 64'(l3[3]), 64'd0);
        chk("t1_l3_c4", 64'(l3[4]), 64'd4);
        chk("t1_l3_c5", 64'(l3[5]), 64'd8);
        chk("t1_l3_c6", 64'(l3[6]), 64'd12);
        chk("t1_l3_c7", 64'(l3[7]), 64'd0);
        chk("t1_done_c8",  64'(dn[8]),  64'd0);
        chk("t1_done_c9",  64'(dn[9]),  64'd1);
        chk("t1_done_c10", 64'(dn[10]), 64'd0);

        // One-cycle gap between two vectors, k_len=2
        bif.start = 1'b1;
        bif.k_len = KW'(2);
        step();
        bif.start    = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_data  = {8'h14, 8'h13, 8'h12, 8'h11};
        step();
        chk("t2_l0_a", 64'(bif.edge_out[0 +: DW]), 64'h11);
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        step();
        chk("t2_l0_bubble", 64'(bif.edge_out[0 +: DW]), 64'h0);
        chk("t2_v0_bubble", 64'(bif.edge_lane_valid[0]), 64'd0);
        chk("t2_l1_a",      64'(bif.edge_out[DW +: DW]), 64'h12);
        bif.in_valid = 1'b1;
        bif.in_data  = {8'h24, 8'h23, 8'h22, 8'h21};
        step();
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        chk("t2_l0_b",      64'(bif.edge_out[0 +: DW]), 64'h21);
        chk("t2_l1_bubble", 64'(bif.edge_out[DW +: DW]), 64'h0);
        wait_done("t2_done_timeout");
`ifdef FEEDER_PERF_EN
        chk("t2_stall", 64'(bif.stall_cnt), 64'd1);
`else
        chk("t2_stall", 64'(bif.stall_cnt), 64'd0);
`endif
        step();

        // Zero-length job
        bif.start = 1'b1;
        bif.k_len = '0;
        step();
        bif.start = 1'b0;
        chk("t3_done",  64'(bif.done),     64'd1);
        chk("t3_acc",   64'(bif.acc_clr),  64'd0);
        chk("t3_busy",  64'(bif.busy),     64'd0);
        chk("t3_ready", 64'(bif.in_ready), 64'd0);
        step();
        chk("t3_done_once", 64'(bif.done), 64'd0);
        chk("t3_busy2",     64'(bif.busy), 64'd0);

        // Reset in the middle of FLUSH, then a normal k_len=1 job
        bif.start = 1'b1;
        bif.k_len = KW'(2);
        step();
        bif.start    = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_data  = {8'h34, 8'h33, 8'h32, 8'h31};
        step();
        bif.in_data  = {8'h44, 8'h43, 8'h42, 8'h41};
        step();
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        step();
        step();
        chk("t4_pre_busy", 64'(bif.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("t4_reset");
        @(negedge clk);
        chk("t4_no_done", 64'(bif.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bif.start = 1'b1;
        bif.k_len = KW'(1);
        step();
        bif.start    = 1'b0;
        chk("t4_acc_clr", 64'(bif.acc_clr), 64'd1);
        bif.in_valid = 1'b1;
        bif.in_data  = {8'h54, 8'h53, 8'h52, 8'h51};
        step();
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        wait_done("t4_done_timeout");
        step();

        // start during LOAD is ignored
        bif.start = 1'b1;
        bif.k_len = KW'(2);
        step();
        bif.k_len = KW'(7);
        accepts = 0;
        dones   = 0;
        for (int k = 0; k < 20; k++) begin
            bif.start    = (k == 0);
            bif.in_valid = (k > 0);
            bif.in_data  = {8'h60, 8'h61, 8'h62, 8'(k)};
            if (bif.in_valid && bif.in_ready) accepts++;
            step();
            if (bif.done) dones++;
        end
        bif.start    = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        chk("t5_accepts", 64'(accepts), 64'd2);
        chk("t5_dones",   64'(dones),   64'd1);
        chk("t5_idle",    64'(bif.busy), 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
